// File: rtl/adc_conv_sequencer.sv
// AD4003 array conversion sequencer: CNV pulse, gated SCK burst, deserialiser
// shift enable and frame latch, all in the adc_spi_clk domain.
module adc_conv_sequencer #(
    parameter int ADC_CHANNELS   = 8,
    parameter int ADC_DATA_WIDTH = 18,
    parameter int CNV_HIGH_CYC   = 24,
    parameter int READ_BITS      = 18,
    parameter int READ_LATENCY   = 4,
    parameter int PERIOD_WIDTH   = 16
) (
    input  logic                                   adc_spi_clk,
    input  logic                                   rst,
    input  logic                                   acq_en,
    input  logic                                   trig_ext,
    input  logic                                   ext_trig,
    input  logic [PERIOD_WIDTH-1:0]                period_cyc,
    input  logic [ADC_DATA_WIDTH*ADC_CHANNELS-1:0] adc_data_arr,
    output logic                                   adc_cnv,
    output logic                                   adc_sck_en,
    output logic                                   reader_en_sync,
    output logic [ADC_DATA_WIDTH*ADC_CHANNELS-1:0] sample_data,
    output logic                                   sample_valid,
    output logic [31:0]                            sample_cnt,
    output logic                                   overrun,
    output logic                                   busy
);

    localparam int MIN_PERIOD = CNV_HIGH_CYC + READ_BITS + READ_LATENCY + 1;
    localparam int FRAME_W    = ADC_DATA_WIDTH * ADC_CHANNELS;
    localparam int RD_LEN     = READ_BITS + READ_LATENCY;
    localparam int CNT_MAX    = (CNV_HIGH_CYC > RD_LEN) ? CNV_HIGH_CYC : RD_LEN;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CNV,
        S_READ,
        S_LATCH
    } state_t;

    function automatic logic [PERIOD_WIDTH-1:0] clamp_period(input logic [PERIOD_WIDTH-1:0] p);
        if (p < PERIOD_WIDTH'(MIN_PERIOD)) begin
            return PERIOD_WIDTH'(MIN_PERIOD);
        end
        return p;
    endfunction

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cyc_q, cyc_d;
    logic                      acq_q;
    logic                      mode_q, mode_d;
    logic [PERIOD_WIDTH-1:0]   period_q, period_d;
    logic                      pend_q, pend_d;
    logic                      per_run_q, per_run_d;
    logic [PERIOD_WIDTH-1:0]   per_cnt_q, per_cnt_d;
    logic                      ovr_q, ovr_d;
    logic [31:0]               cnt_q, cnt_d;
    logic [FRAME_W-1:0]        data_q;
    logic [READ_LATENCY-1:0]   sck_dly_q;

    logic                      start;
    logic                      mode_ext;
    logic [PERIOD_WIDTH-1:0]   period_use;
    logic                      can_accept;
    logic                      req_pend;
    logic                      req_tick;
    logic                      req_ext;
    logic                      accept;
    logic                      drop;
    logic                      frame_done;

    // Trigger qualification: the start-of-acquisition tick waits for a free
    // slot instead of being dropped, so a re-rise mid-frame is never lost.
    always_comb begin
        start      = acq_en & ~acq_q;
        mode_ext   = start ? trig_ext : mode_q;
        period_use = start ? clamp_period(period_cyc) : period_q;
        can_accept = (state_q == S_IDLE) || (state_q == S_LATCH);
        req_pend   = acq_en & ~mode_ext & (start | pend_q);
        req_tick   = acq_en & ~start & ~mode_q & per_run_q & (per_cnt_q == '0);
        req_ext    = acq_en & mode_ext & ext_trig;
        accept     = can_accept & (req_pend | req_tick | req_ext);
        drop       = ~can_accept & (req_tick | req_ext);
        frame_done = (state_q == S_READ) && (cyc_q == CNT_W'(RD_LEN - 1));
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_CNV;
                    cyc_d   = '0;
                end
            end
            S_CNV: begin
                if (cyc_q == CNT_W'(CNV_HIGH_CYC - 1)) begin
                    state_d = S_READ;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CNT_W'(1);
                end
            end
            S_READ: begin
                // READ spans the SCK burst plus the capture latency tail.
                if (frame_done) begin
                    state_d = S_LATCH;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CNT_W'(1);
                end
            end
            S_LATCH: begin
                cyc_d = '0;
                if (accept) begin
                    state_d = S_CNV;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = '0;
            end
        endcase
    end

    always_comb begin
        mode_d    = mode_q;
        period_d  = period_q;
        pend_d    = acq_en & req_pend & ~accept;
        per_run_d = per_run_q;
        per_cnt_d = per_cnt_q;
        if (start) begin
            mode_d   = trig_ext;
            period_d = clamp_period(period_cyc);
        end
        if (!acq_en || mode_ext) begin
            per_run_d = 1'b0;
            per_cnt_d = '0;
        end else if ((req_pend & accept) | req_tick) begin
            per_run_d = 1'b1;
            per_cnt_d = period_use - PERIOD_WIDTH'(1);
        end else if (per_run_q && (per_cnt_q != '0)) begin
            per_cnt_d = per_cnt_q - PERIOD_WIDTH'(1);
        end
        ovr_d = (start ? 1'b0 : ovr_q) | drop;
        cnt_d = (start ? 32'd0 : cnt_q) + (frame_done ? 32'd1 : 32'd0);
    end

    always_ff @(posedge adc_spi_clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cyc_q     <= '0;
            acq_q     <= 1'b0;
            mode_q    <= 1'b0;
            period_q  <= '0;
            pend_q    <= 1'b0;
            per_run_q <= 1'b0;
            per_cnt_q <= '0;
            ovr_q     <= 1'b0;
            cnt_q     <= '0;
            data_q    <= '0;
            sck_dly_q <= '0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            acq_q     <= acq_en;
            mode_q    <= mode_d;
            period_q  <= period_d;
            pend_q    <= pend_d;
            per_run_q <= per_run_d;
            per_cnt_q <= per_cnt_d;
            ovr_q     <= ovr_d;
            cnt_q     <= cnt_d;
            if (frame_done) begin
                data_q <= adc_data_arr;
            end
            sck_dly_q[0] <= adc_sck_en;
            for (int i = 1; i < READ_LATENCY; i++) begin
                sck_dly_q[i] <= sck_dly_q[i-1];
            end
        end
    end

    always_comb begin
        adc_cnv        = (state_q == S_CNV);
        adc_sck_en     = (state_q == S_READ) && (cyc_q < CNT_W'(READ_BITS));
        reader_en_sync = sck_dly_q[READ_LATENCY-1];
        sample_data    = data_q;
        sample_valid   = (state_q == S_LATCH);
        sample_cnt     = cnt_q;
        overrun        = ovr_q;
        busy           = (state_q == S_CNV) || (state_q == S_READ);
    end

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Bench for adc_conv_sequencer: directed scenarios plus random traffic, checked
// every cycle against a trigger-time based reference model.
module tb_adc_conv_sequencer;

    localparam int CH = 8;
    localparam int DW = 18;
    localparam int FW = CH * DW;
    localparam int PW = 16;
    localparam int MINP = 47;

    logic          clk = 1'b0;
    logic          rst, acq_en, trig_ext, ext_trig;
    logic [PW-1:0] period_cyc;
    logic [FW-1:0] adc_data_arr;
    logic          adc_cnv, adc_sck_en, reader_en_sync, sample_valid, overrun, busy;
    logic [FW-1:0] sample_data;
    logic [31:0]   sample_cnt;

    always #5 clk = ~clk;

    adc_conv_sequencer #(
        .ADC_CHANNELS(CH), .ADC_DATA_WIDTH(DW), .CNV_HIGH_CYC(24),
        .READ_BITS(18), .READ_LATENCY(4), .PERIOD_WIDTH(PW)
    ) dut (
        .adc_spi_clk(clk), .rst(rst), .acq_en(acq_en), .trig_ext(trig_ext),
        .ext_trig(ext_trig), .period_cyc(period_cyc), .adc_data_arr(adc_data_arr),
        .adc_cnv(adc_cnv), .adc_sck_en(adc_sck_en), .reader_en_sync(reader_en_sync),
        .sample_data(sample_data), .sample_valid(sample_valid), .sample_cnt(sample_cnt),
        .overrun(overrun), .busy(busy)
    );

    // Reference model: the whole frame is a function of the accepted trigger time.
    int            t;
    int            m_lastT;
    bit            m_acq_q, m_mode, m_pend, m_ovr;
    int            m_next_tick;
    int            m_period;
    int unsigned   m_cnt;
    logic [FW-1:0] m_data;

    int n_vec, n_err;
    int cnv_hi, vcnt, t0;
    int vq[$];
    bit rnd_data;

    function automatic void model_step();
        int  d;
        bit  start, free, acc;
        if (rst) begin
            m_lastT = -1000; m_acq_q = 0; m_mode = 0; m_pend = 0; m_ovr = 0;
            m_next_tick = -1; m_period = 0; m_cnt = 0; m_data = '0;
            return;
        end
        d = t - m_lastT;
        if (d == 46) m_data = adc_data_arr;
        start = acq_en && !m_acq_q;
        if (start) begin
            m_mode      = trig_ext;
            m_period    = (int'(period_cyc) < MINP) ? MINP : int'(period_cyc);
            m_cnt       = 0;
            m_ovr       = 0;
            m_pend      = !trig_ext;
            m_next_tick = -1;
        end
        if (d == 46) m_cnt++;
        free = (d >= 47);
        acc  = 0;
        if (!acq_en) begin
            m_pend = 0;
            m_next_tick = -1;
        end else if (m_mode) begin
            if (ext_trig) begin
                if (free) acc = 1; else m_ovr = 1;
            end
        end else if (m_pend) begin
            if (free) begin
                acc = 1; m_pend = 0; m_next_tick = t + m_period;
            end
        end else if (m_next_tick == t) begin
            m_next_tick = t + m_period;
            if (free) acc = 1; else m_ovr = 1;
        end
        if (acc) m_lastT = t;
        m_acq_q = acq_en;
    endfunction

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    task automatic step();
        int e;
        if (rnd_data)
            for (int c = 0; c < CH; c++) adc_data_arr[c*DW +: DW] = DW'($urandom);
        model_step();
        @(posedge clk);
        #1;
        t++;
        e = t - m_lastT;
        chk("adc_cnv",        FW'(adc_cnv),        FW'(e >= 1  && e <= 24));
        chk("adc_sck_en",     FW'(adc_sck_en),     FW'(e >= 25 && e <= 42));
        chk("reader_en_sync", FW'(reader_en_sync), FW'(e >= 29 && e <= 46));
        chk("busy",           FW'(busy),           FW'(e >= 1  && e <= 46));
        chk("sample_valid",   FW'(sample_valid),   FW'(e == 47));
        chk("overrun",        FW'(overrun),        FW'(m_ovr));
        chk("sample_cnt",     FW'(sample_cnt),     FW'(m_cnt));
        chk("sample_data",    sample_data,         m_data);
        if (adc_cnv) cnv_hi++;
        if (sample_valid) begin
            vcnt++;
            vq.push_back(t);
        end
    endtask

    task automatic clear_stats();
        cnv_hi = 0; vcnt = 0; vq.delete();
    endtask

    initial begin
        n_vec = 0; n_err = 0; t = 0; rnd_data = 0;
        rst = 1; acq_en = 0; trig_ext = 0; ext_trig = 0; period_cyc = '0; adc_data_arr = '0;
        clear_stats();

        // reset and long idle
        repeat (3) step();
        rst = 0;
        clear_stats();
        repeat (200) step();
        chk("idle_cnv_cycles", FW'(cnv_hi), FW'(0));

        // internal mode, period 100, fixed data pattern
        adc_data_arr = {CH{18'h2AAAA}};
        period_cyc = 16'd100; trig_ext = 0; acq_en = 1; t0 = t;
        clear_stats();
        repeat (160) step();
        chk("int_frames",  FW'(vcnt), FW'(2));
        chk("int_valid0",  FW'(vq[0]), FW'(t0 + 47));
        chk("int_valid1",  FW'(vq[1]), FW'(t0 + 147));
        chk("int_cnv_cyc", FW'(cnv_hi), FW'(48));
        chk("int_data",    sample_data, {CH{18'h2AAAA}});
        chk("int_cnt",     FW'(sample_cnt), FW'(2));
        acq_en = 0;
        repeat (60) step();

        // clamp to minimum period, back-to-back frames
        rnd_data = 1;
        period_cyc = 16'd10; acq_en = 1;
        clear_stats();
        repeat (47 * 5) step();
        acq_en = 0;
        repeat (60) step();
        chk("clamp_frames",  FW'(vcnt), FW'(5));
        chk("clamp_overrun", FW'(overrun), FW'(0));

        // external triggers with one dropped
        trig_ext = 1; acq_en = 1;
        clear_stats();
        for (int i = 0; i < 120; i++) begin
            ext_trig = (i == 5 || i == 20 || i == 60);
            step();
        end
        ext_trig = 0;
        chk("ext_frames",  FW'(vcnt), FW'(2));
        chk("ext_overrun", FW'(overrun), FW'(1));
        acq_en = 0; step();
        acq_en = 1; step(); step();
        chk("ext_ovr_clear", FW'(overrun), FW'(0));
        acq_en = 0;
        repeat (60) step();

        // acq_en dropped mid-frame
        trig_ext = 0; period_cyc = 16'd200; acq_en = 1;
        clear_stats();
        repeat (10) step();
        acq_en = 0;
        repeat (100) step();
        chk("stop_frames",  FW'(vcnt), FW'(1));
        chk("stop_cnv_cyc", FW'(cnv_hi), FW'(24));

        // acq_en re-rise while a frame is in flight
        period_cyc = 16'd60; acq_en = 1;
        repeat (20) step();
        acq_en = 0; step();
        acq_en = 1;
        repeat (200) step();
        acq_en = 0;
        repeat (60) step();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) acq_en = ~acq_en;
            trig_ext   = 1'($urandom);
            period_cyc = PW'($urandom_range(0, 130));
            ext_trig   = ($urandom_range(0, 29) == 0);
            rst        = ($urandom_range(0, 799) == 0);
            step();
        end
        rst = 0; acq_en = 0; ext_trig = 0;
        repeat (60) step();

        // reset in the middle of READ
        trig_ext = 0; period_cyc = 16'd100; acq_en = 1;
        clear_stats();
        repeat (35) step();
        rst = 1; step();
        rst = 0; acq_en = 0;
        chk("rst_cnv",   FW'(adc_cnv), FW'(0));
        chk("rst_sck",   FW'(adc_sck_en), FW'(0));
        chk("rst_rden",  FW'(reader_en_sync), FW'(0));
        chk("rst_cnt",   FW'(sample_cnt), FW'(0));
        repeat (60) step();
        chk("rst_frames", FW'(vcnt), FW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
